regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
Owns the single write port of the 32x32 register file. After reset it zero-clears every register, then shares the port between three writeback requesters: ALU result, memory load, and jump-and-link return address. Each requester uses a valid/ready handshake. The block drives the register file's write enable, address and data from registered outputs.

Parameters:
NUM_REGS, 32, number of architectural registers cleared at init
ADDR_W, 5, register index width
DATA_W, 32, register data width
LINK_REG, 31, destination index for link writes
LINK_OFFSET, 2, constant added to link_pc to form the return address

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_reg  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_reg  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
link_valid  in  1  jal link write request
link_ready  out  1  link request accepted this cycle
link_pc  in  DATA_W  PC of the jal instruction
rf_write_en  out  1  register file write enable
rf_write_reg  out  ADDR_W  register file write address
rf_write_data  out  DATA_W  register file write data
init_busy  out  1  high while the clear sequence runs
collision  out  1  registered pulse: more than one valid seen in RUN that cycle

Behaviour:
- Reset (async, rst_n=0):
  - Output values: state=CLEAR, clear index=0, rr pointer=ALU, rf_write_en=0, rf_write_reg=0, rf_write_data=0, collision=0, init_busy=1.
  - All *_ready are forced to 0.
  - Assertion mid-operation abandons any in-flight write; nothing is replayed.
- State CLEAR:
  - Each cycle registers rf_write_en=1, rf_write_reg=index, rf_write_data=0, then increments index.
  - After the write for index NUM_REGS-1 is issued, the next state is RUN.
  - Timing: exactly NUM_REGS write cycles; init_busy deasserts on the first RUN cycle.
  - All *_ready are 0 throughout CLEAR; valids are ignored and not latched.
- State RUN, grant (combinational, same cycle):
  - link has fixed highest priority.
  - Otherwise, ALU and mem are arbitrated round-robin. The rr pointer names the preferred requester. When both are valid, the preferred one is granted and the pointer flips to the other. When only one is valid, it is granted and the pointer moves to the requester that was not granted.
  - At most one ready is high per cycle, and ready is only high for a requester whose valid is high.
  - A transfer occurs when valid & ready.
  - A requester must hold its valid and payload stable until ready.
- Write issue (registered, latency 1): on the edge after a transfer, rf_write_en=1 with the granted register and data.
  - Link write: reg=LINK_REG, data=link_pc+LINK_OFFSET, truncated to DATA_W (wraps modulo 2^DATA_W).
  - No transfer in a cycle: rf_write_en=0 next cycle; rf_write_reg and rf_write_data hold their last values.
- Register 0 rule: a transfer targeting register 0 is accepted (ready=1), but no write is issued (rf_write_en=0). This does not apply during CLEAR.
- Throughput: one write per cycle; a losing requester waits at least 1 cycle.
- collision: registered, so it is high the cycle after a cycle with two or more valids in RUN. It is informational only and does not affect arbitration.

Test Plan:
- Reset release, no requests -> init_busy=1 for cycles 0..31; rf_write_en=1 with rf_write_reg=0..31 and data 0 in order; init_busy=0 from cycle 32; all ready=0 during clear.
- RUN, alu_valid=1 with alu_reg=5 and alu_data=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle rf_write_en=1, rf_write_reg=5, rf_write_data=0xDEADBEEF.
- Three valids in one cycle: link_pc=0x100, alu_reg=3, mem_reg=4 -> cycle 1 link wins (reg 31, data 0x102) and collision=1 the next cycle; cycle 2 ALU (pointer initially ALU); cycle 3 mem.
- alu_valid and mem_valid held high for 6 cycles -> grants alternate ALU, mem, ALU, mem, ALU, mem; no grant repeats back-to-back.
- alu_reg=0 with alu_data=0x1234 -> alu_ready=1, rf_write_en stays 0 the next cycle; link_pc=0xFFFFFFFF -> rf_write_data=0x00000001.
- rst_n pulsed low while writes are streaming -> outputs zero immediately (asynchronously); on release the full 32-cycle clear restarts from index 0 and the pointer is back on ALU.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: clears every register after reset,
// then arbitrates ALU, load and jal-link writebacks onto one registered write port.
module regfile_write_arbiter #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              link_valid,
    output logic              link_ready,
    input  logic [DATA_W-1:0] link_pc,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              init_busy,
    output logic              collision
);

    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic {PREF_ALU, PREF_MEM} pref_t;

    state_t            state, state_next;
    pref_t             rr, rr_next;
    logic [ADDR_W-1:0] clear_idx, clear_idx_next;

    logic              grant_link, grant_alu, grant_mem;
    logic              transfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              multi_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            rr        <= PREF_ALU;
            clear_idx <= '0;
        end else begin
            state     <= state_next;
            rr        <= rr_next;
            clear_idx <= clear_idx_next;
        end
    end

    // Link always wins; ALU and load share the rest round-robin.
    always_comb begin
        state_next     = state;
        rr_next        = rr;
        clear_idx_next = clear_idx;
        grant_link     = 1'b0;
        grant_alu      = 1'b0;
        grant_mem      = 1'b0;
        sel_reg        = '0;
        sel_data       = '0;

        case (state)
            CLEAR: begin
                clear_idx_next = clear_idx + ADDR_W'(1);
                if (clear_idx == ADDR_W'(NUM_REGS - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (link_valid) begin
                    grant_link = 1'b1;
                    sel_reg    = ADDR_W'(LINK_REG);
                    sel_data   = link_pc + DATA_W'(LINK_OFFSET);
                end else if (alu_valid && (rr == PREF_ALU || !mem_valid)) begin
                    grant_alu = 1'b1;
                    sel_reg   = alu_reg;
                    sel_data  = alu_data;
                    rr_next   = PREF_MEM;
                end else if (mem_valid) begin
                    grant_mem = 1'b1;
                    sel_reg   = mem_reg;
                    sel_data  = mem_data;
                    rr_next   = PREF_ALU;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign alu_ready   = grant_alu;
    assign mem_ready   = grant_mem;
    assign link_ready  = grant_link;
    assign transfer    = grant_link | grant_alu | grant_mem;
    assign init_busy   = (state == CLEAR);
    assign multi_valid = (alu_valid & mem_valid) | (alu_valid & link_valid) | (mem_valid & link_valid);

    // Writes to register 0 are swallowed: accepted upstream, never issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            collision     <= 1'b0;
        end else begin
            collision <= (state == RUN) && multi_valid;
            if (state == CLEAR) begin
                rf_write_en   <= 1'b1;
                rf_write_reg  <= clear_idx;
                rf_write_data <= '0;
            end else if (transfer && (sel_reg != '0)) begin
                rf_write_en   <= 1'b1;
                rf_write_reg  <= sel_reg;
                rf_write_data <= sel_data;
            end else begin
                rf_write_en <= 1'b0;
            end
        end
    end

endmodule
